// File: rtl/window_gen.sv
// rtl/window_gen.sv - raster pixel stream to 3x3 neighbourhood windows, credit-throttled by pixel_done
module window_gen #(
    parameter int IMG_WIDTH       = 640,
    parameter int IMG_HEIGHT      = 480,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         pixel_valid,
    input  logic [23:0]  pixel_in,
    input  logic         sof,
    output logic         in_ready,
    input  logic         pixel_done,
    output logic         intensity_enable,
    output logic [215:0] pixelData,
    output logic [9:0]   win_col,
    output logic [8:0]   win_row,
    output logic         frame_done
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    logic [CW-1:0]      col_q, col_d, cur_col;
    logic [RW-1:0]      row_q, row_d, cur_row;
    logic [8:0][23:0]   win_q, win_d;
    logic [215:0]       pixel_data_q, pixel_data_d;
    logic [9:0]         win_col_q, win_col_d;
    logic [8:0]         win_row_q, win_row_d;
    logic               ie_q, ie_d;
    logic               frame_done_q, frame_done_d;
    logic [3:0]         outst_q, outst_d;
    logic [4:0]         load;
    logic               accept, emit, last_pix;
    logic [23:0]        lb0_rd, lb1_rd;

    logic [23:0] lb0_mem [IMG_WIDTH];
    logic [23:0] lb1_mem [IMG_WIDTH];

    // A strobe already registered but not yet counted still consumes a credit.
    assign load     = {1'b0, outst_q} + {4'b0, ie_q};
    assign in_ready = load < 5'(MAX_OUTSTANDING);

    always_comb begin
        accept   = pixel_valid && in_ready;
        cur_col  = sof ? '0 : col_q;
        cur_row  = sof ? '0 : row_q;
        lb0_rd   = lb0_mem[cur_col];
        lb1_rd   = lb1_mem[cur_col];
        emit     = accept && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
        last_pix = accept && (cur_row == ROW_LAST) && (cur_col == COL_LAST);

        col_d        = col_q;
        row_d        = row_q;
        win_d        = win_q;
        pixel_data_d = pixel_data_q;
        win_col_d    = win_col_q;
        win_row_d    = win_row_q;
        ie_d         = emit;
        frame_done_d = last_pix;
        outst_d      = outst_q;

        if (accept) begin
            if (cur_col == COL_LAST) begin
                col_d = '0;
                row_d = (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
            end else begin
                col_d = cur_col + CW'(1);
                row_d = cur_row;
            end
            for (int r = 0; r < 3; r++) begin
                win_d[r*3]     = win_q[r*3 + 1];
                win_d[r*3 + 1] = win_q[r*3 + 2];
            end
            win_d[2] = lb0_rd;
            win_d[5] = lb1_rd;
            win_d[8] = pixel_in;
        end

        // Window slot 0 (top-left) lands in the most significant word.
        if (emit) begin
            for (int k = 0; k < 9; k++) begin
                pixel_data_d[215 - 24*k -: 24] = win_d[k];
            end
            win_col_d = 10'(cur_col - CW'(1));
            win_row_d = 9'(cur_row - RW'(1));
        end

        if (ie_q && !pixel_done) begin
            outst_d = outst_q + 4'd1;
        end else if (!ie_q && pixel_done && (outst_q != 4'd0)) begin
            outst_d = outst_q - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            col_q        <= '0;
            row_q        <= '0;
            win_q        <= '0;
            pixel_data_q <= '0;
            win_col_q    <= '0;
            win_row_q    <= '0;
            ie_q         <= 1'b0;
            frame_done_q <= 1'b0;
            outst_q      <= '0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            win_q        <= win_d;
            pixel_data_q <= pixel_data_d;
            win_col_q    <= win_col_d;
            win_row_q    <= win_row_d;
            ie_q         <= ie_d;
            frame_done_q <= frame_done_d;
            outst_q      <= outst_d;
        end
    end

    // Line-buffer contents need no reset; the window is refilled before any emit.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb0_mem[cur_col] <= lb1_rd;
            lb1_mem[cur_col] <= pixel_in;
        end
    end

    assign intensity_enable = ie_q;
    assign pixelData        = pixel_data_q;
    assign win_col          = win_col_q;
    assign win_row          = win_row_q;
    assign frame_done       = frame_done_q;

endmodule

// File: tb/tb_window_gen.sv
// tb/tb_window_gen.sv - scoreboard bench for window_gen on a 4x4 and an 8x6 frame
module tb_window_gen;

    typedef struct {
        logic [215:0] data;
        int           row;
        int           col;
        int           cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         a_rst, a_valid, a_sof, a_ready, a_done, a_ie, a_fd;
    logic [23:0]  a_pix;
    logic [215:0] a_data;
    logic [9:0]   a_wcol;
    logic [8:0]   a_wrow;

    logic         b_rst, b_valid, b_sof, b_ready, b_done, b_ie, b_fd;
    logic [23:0]  b_pix;
    logic [215:0] b_data;
    logic [9:0]   b_wcol;
    logic [8:0]   b_wrow;

    window_gen #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .MAX_OUTSTANDING(2)) dut_a (
        .clk(clk), .n_rst(a_rst), .pixel_valid(a_valid), .pixel_in(a_pix), .sof(a_sof),
        .in_ready(a_ready), .pixel_done(a_done), .intensity_enable(a_ie), .pixelData(a_data),
        .win_col(a_wcol), .win_row(a_wrow), .frame_done(a_fd)
    );

    window_gen #(.IMG_WIDTH(8), .IMG_HEIGHT(6), .MAX_OUTSTANDING(4)) dut_b (
        .clk(clk), .n_rst(b_rst), .pixel_valid(b_valid), .pixel_in(b_pix), .sof(b_sof),
        .in_ready(b_ready), .pixel_done(b_done), .intensity_enable(b_ie), .pixelData(b_data),
        .win_col(b_wcol), .win_row(b_wrow), .frame_done(b_fd)
    );

    int           checks = 0;
    int           errors = 0;
    exp_t         sb_a[$];
    exp_t         sb_b[$];
    logic [23:0]  img [2][6][8];
    int           mrow [2];
    int           mcol [2];
    int           strobes [2];
    logic [215:0] first_win [2];
    bit           fd_exp [2];
    bit           acc_last [2];
    bit           auto_a;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [215:0] pack9(input int v[9]);
        logic [215:0] r;
        r = '0;
        for (int k = 0; k < 9; k++) r[215 - 24*k -: 24] = 24'(v[k]);
        return r;
    endfunction

    task automatic model_accept(input int d, input logic [23:0] pix, input logic s);
        int   w, h;
        exp_t e;
        w = (d == 0) ? 4 : 8;
        h = (d == 0) ? 4 : 6;
        if (s) begin
            mrow[d] = 0;
            mcol[d] = 0;
        end
        img[d][mrow[d]][mcol[d]] = pix;
        if (mrow[d] >= 2 && mcol[d] >= 2) begin
            e.data = '0;
            for (int k = 0; k < 9; k++)
                e.data[215 - 24*k -: 24] = img[d][mrow[d] - 2 + k/3][mcol[d] - 2 + k%3];
            e.row = mrow[d] - 1;
            e.col = mcol[d] - 1;
            e.cyc = cyc;
            if (d == 0) sb_a.push_back(e);
            else        sb_b.push_back(e);
        end
        fd_exp[d] = (mrow[d] == h - 1) && (mcol[d] == w - 1);
        if (mcol[d] == w - 1) begin
            mcol[d] = 0;
            mrow[d] = (mrow[d] == h - 1) ? 0 : mrow[d] + 1;
        end else begin
            mcol[d] = mcol[d] + 1;
        end
    endtask

    task automatic check_out(input int d);
        logic         ie, fd;
        logic [215:0] data;
        int           wr, wc;
        exp_t         e;
        ie   = (d == 0) ? a_ie   : b_ie;
        fd   = (d == 0) ? a_fd   : b_fd;
        data = (d == 0) ? a_data : b_data;
        wr   = (d == 0) ? int'(a_wrow) : int'(b_wrow);
        wc   = (d == 0) ? int'(a_wcol) : int'(b_wcol);
        if (ie) begin
            if ((d == 0 && sb_a.size() == 0) || (d == 1 && sb_b.size() == 0)) begin
                chk("strobe_unexpected", 1, 0);
            end else begin
                e = (d == 0) ? sb_a.pop_front() : sb_b.pop_front();
                chk("win_data", data, e.data);
                chk("win_row", wr, e.row);
                chk("win_col", wc, e.col);
                chk("latency", cyc, e.cyc + 1);
            end
            if (strobes[d] == 0) first_win[d] = data;
            strobes[d]++;
        end
        if (fd || fd_exp[d]) chk("frame_done", fd, fd_exp[d]);
    endtask

    task automatic tick(input int d);
        fd_exp[d] = 1'b0;
        if (d == 0) begin
            acc_last[0] = a_valid && a_ready;
            if (acc_last[0]) model_accept(0, a_pix, a_sof);
        end else begin
            acc_last[1] = b_valid && b_ready;
            if (acc_last[1]) model_accept(1, b_pix, b_sof);
        end
        @(posedge clk);
        #1;
        check_out(d);
        if (d == 0 && auto_a) a_done = a_ie;
    endtask

    task automatic feed_a(input int v, input logic s);
        int n;
        n = 0;
        a_valid = 1'b1;
        a_pix   = 24'(v);
        a_sof   = s;
        do begin
            tick(0);
            n++;
        end while (!acc_last[0] && n < 50);
        if (!acc_last[0]) chk("accept_timeout", 0, 1);
        a_sof = 1'b0;
    endtask

    task automatic reset_a();
        a_rst   = 1'b1;
        a_valid = 1'b0;
        a_sof   = 1'b0;
        a_done  = 1'b0;
        sb_a.delete();
        mrow[0] = 0;
        mcol[0] = 0;
        strobes[0] = 0;
        fd_exp[0] = 1'b0;
        @(posedge clk);
        #1;
        a_rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int v[9];
        int idx, owed;

        a_rst = 1'b1; a_valid = 1'b0; a_sof = 1'b0; a_done = 1'b0; a_pix = '0;
        b_rst = 1'b1; b_valid = 1'b0; b_sof = 1'b0; b_done = 1'b0; b_pix = '0;
        auto_a = 1'b0;
        strobes[0] = 0; strobes[1] = 0;
        mrow[0] = 0; mcol[0] = 0; mrow[1] = 0; mcol[1] = 0;
        fd_exp[0] = 1'b0; fd_exp[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", a_ready, 1);
        chk("rst_ie", a_ie, 0);
        chk("rst_pixeldata", a_data, 0);
        chk("rst_frame_done", a_fd, 0);
        chk("rst_win_col", a_wcol, 0);
        chk("rst_win_row", a_wrow, 0);

        // Full 4x4 frame, pixel_done echoed one cycle after each strobe.
        reset_a();
        auto_a = 1'b1;
        for (int i = 0; i < 16; i++) feed_a(i, 1'b0);
        a_valid = 1'b0;
        repeat (4) tick(0);
        v = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
        chk("t1_strobes", strobes[0], 4);
        chk("t1_first_win", first_win[0], pack9(v));
        chk("t1_sb_empty", sb_a.size(), 0);

        // No pixel_done: credit exhausts after two strobes, index 12 held.
        reset_a();
        auto_a = 1'b0;
        for (int i = 0; i < 12; i++) feed_a(i, 1'b0);
        a_valid = 1'b1;
        a_pix   = 24'd12;
        repeat (4) tick(0);
        chk("t2_strobes", strobes[0], 2);
        chk("t2_ready_low", a_ready, 0);
        chk("t2_held", acc_last[0], 0);
        a_done = 1'b1;
        tick(0);
        a_done = 1'b0;
        chk("t2_ready_back", a_ready, 1);
        tick(0);
        chk("t2_accept12", acc_last[0], 1);

        // Strobe and pixel_done together at outst=1, then pixel_done at outst=0.
        feed_a(13, 1'b0);
        feed_a(14, 1'b0);
        chk("t3_ie", a_ie, 1);
        a_valid = 1'b0;
        a_done  = 1'b1;
        tick(0);
        a_done  = 1'b0;
        chk("t3_outst1_ready", a_ready, 1);
        feed_a(15, 1'b0);
        a_valid = 1'b0;
        chk("t3_simul_keep", a_ready, 0);
        a_done = 1'b1;
        repeat (3) tick(0);
        a_done = 1'b0;
        for (int i = 0; i < 11; i++) feed_a(i, 1'b0);
        a_valid = 1'b0;
        chk("t3_ie_next_frame", a_ie, 1);
        chk("t3_no_underflow", a_ready, 1);
        tick(0);

        // sof mid-frame on index 6 restarts counting at that pixel.
        reset_a();
        auto_a = 1'b1;
        for (int i = 0; i < 6; i++) feed_a(i, 1'b0);
        feed_a(6, 1'b1);
        for (int i = 7; i < 16; i++) feed_a(i, 1'b0);
        chk("t4_no_early", strobes[0], 0);
        for (int i = 16; i < 22; i++) feed_a(i, 1'b0);
        a_valid = 1'b0;
        repeat (4) tick(0);
        v = '{6, 7, 8, 10, 11, 12, 14, 15, 16};
        chk("t4_strobes", strobes[0], 4);
        chk("t4_first_win", first_win[0], pack9(v));

        // Asynchronous reset between edges while a strobe is showing.
        reset_a();
        auto_a = 1'b1;
        for (int i = 0; i < 11; i++) feed_a(i, 1'b0);
        chk("t5_pre_ie", a_ie, 1);
        #2 a_rst = 1'b1;
        #1;
        chk("t5_ie_clr", a_ie, 0);
        chk("t5_data_clr", a_data, 0);
        chk("t5_row_clr", a_wrow, 0);
        chk("t5_col_clr", a_wcol, 0);
        chk("t5_ready", a_ready, 1);
        #1 a_rst = 1'b0;
        a_done = 1'b0;
        sb_a.delete();
        mrow[0] = 0;
        mcol[0] = 0;
        strobes[0] = 0;
        for (int i = 0; i < 16; i++) feed_a(100 + i, 1'b0);
        a_valid = 1'b0;
        repeat (4) tick(0);
        v = '{100, 101, 102, 104, 105, 106, 108, 109, 110};
        chk("t5_strobes", strobes[0], 4);
        chk("t5_first_win", first_win[0], pack9(v));
        auto_a = 1'b0;

        // 8x6 frame with random valid gaps and randomly delayed pixel_done.
        @(posedge clk);
        #1;
        b_rst = 1'b0;
        idx   = 0;
        owed  = 0;
        b_pix = 24'($urandom);
        for (int c = 0; c < 3000 && !(idx == 48 && strobes[1] == 24); c++) begin
            b_valid = (idx < 48) && ($urandom_range(0, 2) != 0);
            b_done  = (owed > 0) && ($urandom_range(0, 1) == 1);
            if (b_done) owed--;
            tick(1);
            if (acc_last[1]) begin
                idx++;
                b_pix = 24'($urandom);
            end
            if (b_ie) owed++;
        end
        b_valid = 1'b0;
        b_done  = 1'b0;
        chk("t6_accepted", idx, 48);
        chk("t6_strobes", strobes[1], 24);
        chk("t6_sb_empty", sb_b.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
